// File: rtl/dsp_seq_pkg.sv
// Shared widths, opcode encodings and the slice drive bundle for the
// DSP48E1 operation sequencer.
package dsp_seq_pkg;

    localparam int A_W       = 30;
    localparam int B_W       = 18;
    localparam int INMODE_W  = 5;
    localparam int ALUMODE_W = 4;
    localparam int OPMODE_W  = 7;
    localparam int P_W       = 48;

    // Control values driven on cycles with no new operation.
    localparam logic [OPMODE_W-1:0]  OPMODE_NOP  = 7'b0;
    localparam logic [ALUMODE_W-1:0] ALUMODE_ADD = 4'b0;
    localparam logic [INMODE_W-1:0]  INMODE_DEF  = 5'b0;

    // Frequently used OPMODE encodings.
    localparam logic [OPMODE_W-1:0] OPMODE_MUL       = 7'b000_0101;
    localparam logic [OPMODE_W-1:0] OPMODE_MUL_ADD_C = 7'b011_0101;

    // Everything the sequencer drives into the slice in one cycle.
    typedef struct packed {
        logic [A_W-1:0]       a;
        logic [B_W-1:0]       b;
        logic [INMODE_W-1:0]  inmode;
        logic [ALUMODE_W-1:0] alumode;
        logic [OPMODE_W-1:0]  opmode;
    } dsp_ctrl_t;

endpackage

// File: rtl/dsp_result_fifo.sv
// First-word-fall-through result FIFO. Pointers wrap modulo DEPTH; a
// separate occupancy count gives full/empty. overflow_o flags a write
// that found the FIFO full so the enclosing design can assert on it.
module dsp_result_fifo
    import dsp_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = P_W + 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_ready_i,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, push, pop;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign push       = wr_en_i && !full;
    assign pop        = rd_ready_i && !empty;
    assign overflow_o = wr_en_i && full;
    assign rd_valid_o = !empty;
    assign rd_data_o  = mem_q[rd_ptr_q];

    // Next pointer and occupancy values from this cycle's push/pop.
    always_comb begin
        // NOTE: every signal gets a default before any condition, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so the read port shows zero after reset.
    always_ff @(posedge clk) begin
        // NOTE: the storage is reset here only because it is tiny and the output must read zero after reset; larger memories are normally left unreset.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/dsp_op_sequencer.sv
// Issue stage for a DSP48E1 slice: accepts tagged operations, drives the
// slice inputs, follows each operation through the fixed slice latency and
// captures P into a result FIFO. Credits bound the ops in flight to the
// FIFO depth because the slice pipeline itself can never stall.
module dsp_op_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          op_valid,
    output logic                          op_ready,
    input  logic [A_W-1:0]                op_a,
    input  logic [B_W-1:0]                op_b,
    input  logic [INMODE_W-1:0]           op_inmode,
    input  logic [ALUMODE_W-1:0]          op_alumode,
    input  logic [OPMODE_W-1:0]           op_opmode,
    input  logic [TAG_W-1:0]              op_tag,
    output logic [A_W-1:0]                dsp_a,
    output logic [B_W-1:0]                dsp_b,
    output logic [INMODE_W-1:0]           dsp_inmode,
    output logic [ALUMODE_W-1:0]          dsp_alumode,
    output logic [OPMODE_W-1:0]           dsp_opmode,
    input  logic [P_W-1:0]                dsp_p,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [P_W-1:0]                res_p,
    output logic [TAG_W-1:0]              res_tag,
    output logic [$clog2(FIFO_DEPTH):0]   outstanding,
    output logic                          idle
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int FIFO_W = P_W + TAG_W;

    dsp_ctrl_t                   dsp_q, dsp_d;
    logic [CNT_W-1:0]            outstanding_q, outstanding_d;
    logic [LATENCY:0]            trk_valid_q, trk_valid_d;
    logic [LATENCY:0][TAG_W-1:0] trk_tag_q, trk_tag_d;
    logic [FIFO_W-1:0]           fifo_rd_data;
    logic                        accept, pop, fifo_overflow;

    assign op_ready = !rst && (outstanding_q < CNT_W'(FIFO_DEPTH));
    assign accept   = op_valid && op_ready;
    assign pop      = res_valid && res_ready;

    // Next slice drive, tracking pipe and credit count.
    always_comb begin
        dsp_d         = dsp_q;
        dsp_d.inmode  = INMODE_DEF;
        dsp_d.alumode = ALUMODE_ADD;
        dsp_d.opmode  = OPMODE_NOP;
        if (accept) begin
            dsp_d.a       = op_a;
            dsp_d.b       = op_b;
            dsp_d.inmode  = op_inmode;
            dsp_d.alumode = op_alumode;
            dsp_d.opmode  = op_opmode;
        end
        // Entry k tracks an op accepted k+1 edges ago; the last entry marks
        // the cycle in which dsp_p holds that op's result.
        trk_valid_d   = {trk_valid_q[LATENCY-1:0], accept};
        trk_tag_d     = {trk_tag_q[LATENCY-1:0], op_tag};
        outstanding_d = outstanding_q;
        case ({accept, pop})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State registers; reset drops every in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            dsp_q         <= '0;
            outstanding_q <= '0;
            trk_valid_q   <= '0;
            trk_tag_q     <= '0;
        end else begin
            dsp_q         <= dsp_d;
            outstanding_q <= outstanding_d;
            trk_valid_q   <= trk_valid_d;
            trk_tag_q     <= trk_tag_d;
        end
    end

    assign dsp_a       = dsp_q.a;
    assign dsp_b       = dsp_q.b;
    assign dsp_inmode  = dsp_q.inmode;
    assign dsp_alumode = dsp_q.alumode;
    assign dsp_opmode  = dsp_q.opmode;
    assign outstanding = outstanding_q;
    assign idle        = (outstanding_q == '0);

    dsp_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_result_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (trk_valid_q[LATENCY]),
        .wr_data_i  ({trk_tag_q[LATENCY], dsp_p}),
        .rd_ready_i (res_ready),
        .rd_valid_o (res_valid),
        .rd_data_o  (fifo_rd_data),
        .overflow_o (fifo_overflow)
    );

    assign {res_tag, res_p} = fifo_rd_data;

    // The credit count must make a write into a full FIFO impossible.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst) !fifo_overflow);

endmodule

// File: tb/tb_dsp_op_sequencer.sv
// Self-checking bench for dsp_op_sequencer: behavioural slice model, a
// result scoreboard checked every cycle, table-driven single operations,
// directed flow-control/reset sequences and a randomized run.
module tb_dsp_op_sequencer;
    import dsp_seq_pkg::*;

    localparam int LATENCY    = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W      = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int NVEC       = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 op_valid = 1'b0;
    logic                 op_ready;
    logic [A_W-1:0]       op_a = '0;
    logic [B_W-1:0]       op_b = '0;
    logic [INMODE_W-1:0]  op_inmode = '0;
    logic [ALUMODE_W-1:0] op_alumode = '0;
    logic [OPMODE_W-1:0]  op_opmode = '0;
    logic [TAG_W-1:0]     op_tag = '0;
    logic [A_W-1:0]       dsp_a;
    logic [B_W-1:0]       dsp_b;
    logic [INMODE_W-1:0]  dsp_inmode;
    logic [ALUMODE_W-1:0] dsp_alumode;
    logic [OPMODE_W-1:0]  dsp_opmode;
    logic [P_W-1:0]       dsp_p;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [P_W-1:0]       res_p;
    logic [TAG_W-1:0]     res_tag;
    logic [CNT_W-1:0]     outstanding;
    logic                 idle;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dsp_op_sequencer #(
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (TAG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_inmode   (op_inmode),
        .op_alumode  (op_alumode),
        .op_opmode   (op_opmode),
        .op_tag      (op_tag),
        .dsp_a       (dsp_a),
        .dsp_b       (dsp_b),
        .dsp_inmode  (dsp_inmode),
        .dsp_alumode (dsp_alumode),
        .dsp_opmode  (dsp_opmode),
        .dsp_p       (dsp_p),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_p       (res_p),
        .res_tag     (res_tag),
        .outstanding (outstanding),
        .idle        (idle)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, want, $time);
    endtask

    // Slice behaviour: signed A[24:0] * B when OPMODE selects the multiplier, else 0.
    function automatic logic [P_W-1:0] slice_fn(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                                input logic [OPMODE_W-1:0] opm);
        logic signed [24:0]    as;
        logic signed [B_W-1:0] bs;
        logic signed [P_W-1:0] r;
        as = a[24:0];
        bs = b;
        r  = as * bs;
        return (opm == OPMODE_MUL) ? r : '0;
    endfunction

    // Slice model: input register, multiplier register, P register.
    logic [A_W-1:0]      s_a;
    logic [B_W-1:0]      s_b;
    logic [OPMODE_W-1:0] s_op;
    logic [P_W-1:0]      s_m, s_p;
    always @(posedge clk) begin
        s_a  <= dsp_a;
        s_b  <= dsp_b;
        s_op <= dsp_opmode;
        s_m  <= slice_fn(s_a, s_b, s_op);
        s_p  <= s_m;
    end
    assign dsp_p = s_p;

    // Scoreboard: results expected in accept order, plus expected slice drive.
    typedef struct { logic [P_W-1:0] p; logic [TAG_W-1:0] tag; } res_t;
    res_t                 exp_q[$];
    logic [A_W-1:0]       e_a;
    logic [B_W-1:0]       e_b;
    logic [INMODE_W-1:0]  e_inmode;
    logic [ALUMODE_W-1:0] e_alumode;
    logic [OPMODE_W-1:0]  e_opmode;
    bit                   model_live = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            e_a = '0; e_b = '0; e_inmode = '0; e_alumode = '0; e_opmode = '0;
            model_live = 1'b1;
            check("op_ready_in_rst", op_ready, 1'b0);
        end else if (model_live) begin
            check("outstanding", outstanding, exp_q.size());
            check("idle", idle, exp_q.size() == 0);
            check("op_ready", op_ready, exp_q.size() < FIFO_DEPTH);
            check("dsp_a", dsp_a, e_a);
            check("dsp_b", dsp_b, e_b);
            check("dsp_inmode", dsp_inmode, e_inmode);
            check("dsp_alumode", dsp_alumode, e_alumode);
            check("dsp_opmode", dsp_opmode, e_opmode);
            if (exp_q.size() == 0) begin
                check("res_valid_when_empty", res_valid, 1'b0);
            end else if (res_valid) begin
                check("res_p", res_p, exp_q[0].p);
                check("res_tag", res_tag, exp_q[0].tag);
                if (res_ready) void'(exp_q.pop_front());
            end
            if (op_valid && op_ready) begin
                exp_q.push_back('{p: slice_fn(op_a, op_b, op_opmode), tag: op_tag});
                e_a = op_a; e_b = op_b; e_inmode = op_inmode; e_alumode = op_alumode; e_opmode = op_opmode;
            end else begin
                e_inmode = '0; e_alumode = '0; e_opmode = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                          input logic [OPMODE_W-1:0] opm, input logic [TAG_W-1:0] tag);
        op_valid   = 1'b1;
        op_a       = a;
        op_b       = b;
        op_opmode  = opm;
        op_tag     = tag;
        op_inmode  = 5'(tag);
        op_alumode = ALUMODE_ADD;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!idle && n < 50) begin
            tick();
            @(negedge clk);
            n++;
        end
        check("idle_reached", idle, 1'b1);
        tick();
    endtask

    typedef struct {
        logic [A_W-1:0]      a;
        logic [B_W-1:0]      b;
        logic [OPMODE_W-1:0] opm;
        logic [TAG_W-1:0]    tag;
        logic [P_W-1:0]      p;
    } vec_t;
    vec_t vecs[NVEC];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int edges, seen, acc, first;
        bit found;

        vecs[0] = '{a: 30'd3,          b: 18'd5,       opm: OPMODE_MUL, tag: 4'd1, p: 48'd15};
        vecs[1] = '{a: 30'h3FFFFFFE,   b: 18'd7,       opm: OPMODE_MUL, tag: 4'd2, p: 48'hFFFF_FFFF_FFF2};
        vecs[2] = '{a: 30'h3E000005,   b: 18'h3FFFF,   opm: OPMODE_MUL, tag: 4'd3, p: 48'hFFFF_FFFF_FFFB};
        vecs[3] = '{a: 30'h00FFFFFF,   b: 18'h1FFFF,   opm: OPMODE_MUL, tag: 4'd4, p: 48'h01FF_FEFE_0001};
        vecs[4] = '{a: 30'h01000000,   b: 18'h20000,   opm: OPMODE_MUL, tag: 4'd5, p: 48'h0200_0000_0000};
        vecs[5] = '{a: 30'd9,          b: 18'd9,       opm: OPMODE_NOP, tag: 4'd6, p: 48'd0};

        // Reset state, sampled while reset is still held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dsp_a", dsp_a, 0);
        check("rst_dsp_b", dsp_b, 0);
        check("rst_dsp_inmode", dsp_inmode, 0);
        check("rst_dsp_alumode", dsp_alumode, 0);
        check("rst_dsp_opmode", dsp_opmode, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_p", res_p, 0);
        check("rst_res_tag", res_tag, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_idle", idle, 1);
        check("rst_op_ready", op_ready, 0);
        tick();
        rst = 1'b0;

        // Single operations: latency, bit-exact signed product, tag.
        for (int i = 0; i < NVEC; i++) begin
            wait_idle();
            res_ready = 1'b1;
            set_op(vecs[i].a, vecs[i].b, vecs[i].opm, vecs[i].tag);
            @(negedge clk);
            check("tbl_op_ready", op_ready, 1'b1);
            tick();
            op_valid = 1'b0;
            edges = 0;
            found = 1'b0;
            while (!found && edges < 20) begin
                @(negedge clk);
                if (res_valid) found = 1'b1;
                else begin
                    tick();
                    edges++;
                end
            end
            check("tbl_latency", edges, LATENCY + 1);
            check("tbl_res_p", res_p, vecs[i].p);
            check("tbl_res_tag", res_tag, vecs[i].tag);
            tick();
        end

        // Four back-to-back ops: full throughput, results on consecutive cycles.
        wait_idle();
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(30'(i + 1), 18'd10, OPMODE_MUL, 4'(i));
            @(negedge clk);
            check("b2b_op_ready", op_ready, 1'b1);
            tick();
        end
        op_valid = 1'b0;
        seen = 0;
        first = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (res_valid) begin
                if (first < 0) first = c;
                check("b2b_res_p", res_p, 48'((seen + 1) * 10));
                check("b2b_res_tag", res_tag, seen);
                check("b2b_consecutive", c - first, seen);
                seen++;
            end
            tick();
        end
        check("b2b_count", seen, 4);

        // Credit limit: only FIFO_DEPTH ops accepted while results are held.
        wait_idle();
        res_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            set_op(30'(20 + acc), 18'd3, OPMODE_MUL, 4'(8 + acc));
            @(negedge clk);
            if (op_ready) acc++;
            tick();
        end
        op_valid = 1'b0;
        @(negedge clk);
        check("credit_accepted", acc, 4);
        check("credit_op_ready", op_ready, 1'b0);
        check("credit_outstanding", outstanding, 4);
        tick();
        res_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 40 && seen < 6; c++) begin
            if (acc < 6) set_op(30'(20 + acc), 18'd3, OPMODE_MUL, 4'(8 + acc));
            else op_valid = 1'b0;
            @(negedge clk);
            if (op_valid && op_ready) acc++;
            if (res_valid) begin
                check("credit_res_tag", res_tag, 8 + seen);
                check("credit_res_p", res_p, 48'(3 * (20 + seen)));
                seen++;
            end
            tick();
        end
        op_valid = 1'b0;
        check("credit_total_accepted", acc, 6);
        check("credit_total_results", seen, 6);

        // Simultaneous accept and pop around the full point.
        wait_idle();
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_op(30'(i + 1), 18'd2, OPMODE_MUL, 4'(i));
            tick();
        end
        op_valid = 1'b0;
        repeat (8) tick();
        set_op(30'd7, 18'd7, OPMODE_MUL, 4'd12);
        res_ready = 1'b1;
        @(negedge clk);
        check("full_outstanding", outstanding, 4);
        check("full_op_ready", op_ready, 1'b0);
        check("full_res_valid", res_valid, 1'b1);
        tick();
        @(negedge clk);
        check("pop_only_outstanding", outstanding, 3);
        check("pop_only_op_ready", op_ready, 1'b1);
        tick();
        res_ready = 1'b0;
        set_op(30'd8, 18'd8, OPMODE_MUL, 4'd13);
        @(negedge clk);
        check("acc_pop_outstanding", outstanding, 3);
        check("acc_pop_op_ready", op_ready, 1'b1);
        tick();
        op_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("acc_only_outstanding", outstanding, 4);
        check("acc_only_op_ready", op_ready, 1'b0);
        tick();
        @(negedge clk);
        check("pop2_outstanding", outstanding, 3);
        check("pop2_op_ready", op_ready, 1'b1);
        tick();
        wait_idle();

        // Reset with two ops in flight: nothing may emerge afterwards.
        res_ready = 1'b1;
        set_op(30'd11, 18'd11, OPMODE_MUL, 4'd5);
        tick();
        set_op(30'd12, 18'd12, OPMODE_MUL, 4'd6);
        tick();
        op_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_op_ready", op_ready, 1'b0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("midrst_res_valid", res_valid, 1'b0);
            check("midrst_outstanding", outstanding, 0);
            check("midrst_dsp_opmode", dsp_opmode, 0);
            tick();
        end

        // Randomized traffic against the scoreboard.
        for (int c = 0; c < 600; c++) begin
            op_valid   = ($urandom_range(0, 3) != 0);
            op_a       = 30'($urandom());
            op_b       = 18'($urandom());
            op_inmode  = 5'($urandom());
            op_alumode = 4'($urandom());
            op_opmode  = ($urandom_range(0, 4) == 0) ? OPMODE_MUL_ADD_C : OPMODE_MUL;
            op_tag     = 4'($urandom());
            res_ready  = ($urandom_range(0, 2) != 0);
            tick();
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        wait_idle();
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
